ball_motion_engine: RTL and testbench

Single-clock ball physics and scoring stage inside the game controller domain. Each position step, it advances the ball one pixel per axis and bounces it off the top/bottom walls and paddle faces. It detects misses, keeps both scores, and sequences serve, play and game-over. Its ball position outputs feed the packed position word that crosses to the graphics clock domain.

---
 rtl/game_constants_pkg.sv | 40 ++++
 rtl/position_step_ticker.sv | 30 +++
 rtl/ball_motion_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_constants_pkg.sv
// Shared game-controller constants, default tunables and small types used by
// the ball motion engine and the paddle motion logic.
package game_constants_pkg;

  // Playfield geometry in pixels
  localparam int TOTAL_WIDTH    = 64;
  localparam int TOTAL_HEIGHT   = 48;
  localparam int PADDLE_WIDTH   = 2;
  localparam int PADDLE_HEIGHT  = 12;
  localparam int BALL_SIDE_SIZE = 2;

  // Half-width of the paddle-centre band that leaves the vertical direction alone
  localparam int BALL_OFFSET_RANGE = 2;

  // Fixed paddle columns and the serve position
  localparam int INITIAL_PADDLE_1_X = 4;
  localparam int INITIAL_PADDLE_2_X = 58;
  localparam int INITIAL_BALL_X     = 31;
  localparam int INITIAL_BALL_Y     = 23;

  // Clocks between movement steps
  localparam int POSITION_CHANGE_FREQ_IN_CLOCKS = 4;

  // Defaults for the ball engine tunables
  localparam int SERVE_DELAY_IN_STEPS_DEFAULT = 64;
  localparam int WINNING_SCORE_DEFAULT        = 9;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    IN_PLAY    = 2'd1,
    GAME_OVER  = 2'd2
  } ball_state_t;

  // DIR_FWD is rightwards on x and downwards on y; DIR_BACK is the opposite
  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } dir_t;

endpackage

// File: rtl/position_step_ticker.sv
// Wrapping clock divider that marks one movement step per period.
// The strobe is high on the cycle the counter sits at its maximum.
module position_step_ticker #(
  parameter int POSITION_CHANGE_FREQ_IN_CLOCKS = game_constants_pkg::POSITION_CHANGE_FREQ_IN_CLOCKS
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  localparam int CW = (POSITION_CHANGE_FREQ_IN_CLOCKS > 1) ? $clog2(POSITION_CHANGE_FREQ_IN_CLOCKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(POSITION_CHANGE_FREQ_IN_CLOCKS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] count;

  // Count 0..max and wrap; active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CNT_ONE;
    end
  end

  assign step = (count == CNT_MAX);

endmodule

// File: rtl/ball_motion_engine.sv
// Ball physics and scoring: moves the ball one pixel per axis on each step,
// bounces off walls and paddle faces, detects misses, keeps scores and
// sequences serve / play / game-over. All outputs are registered.
module ball_motion_engine #(
  parameter int POSITION_CHANGE_FREQ_IN_CLOCKS = game_constants_pkg::POSITION_CHANGE_FREQ_IN_CLOCKS,
  parameter int TOTAL_WIDTH          = game_constants_pkg::TOTAL_WIDTH,
  parameter int TOTAL_HEIGHT         = game_constants_pkg::TOTAL_HEIGHT,
  parameter int PADDLE_WIDTH         = game_constants_pkg::PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT        = game_constants_pkg::PADDLE_HEIGHT,
  parameter int BALL_SIDE_SIZE       = game_constants_pkg::BALL_SIDE_SIZE,
  parameter int BALL_OFFSET_RANGE    = game_constants_pkg::BALL_OFFSET_RANGE,
  parameter int INITIAL_PADDLE_1_X   = game_constants_pkg::INITIAL_PADDLE_1_X,
  parameter int INITIAL_PADDLE_2_X   = game_constants_pkg::INITIAL_PADDLE_2_X,
  parameter int INITIAL_BALL_X       = game_constants_pkg::INITIAL_BALL_X,
  parameter int INITIAL_BALL_Y       = game_constants_pkg::INITIAL_BALL_Y,
  parameter int SERVE_DELAY_IN_STEPS = game_constants_pkg::SERVE_DELAY_IN_STEPS_DEFAULT,
  parameter int WINNING_SCORE        = game_constants_pkg::WINNING_SCORE_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(TOTAL_HEIGHT+1):0]   paddle_1_pos,
  input  logic [$clog2(TOTAL_HEIGHT+1):0]   paddle_2_pos,
  output logic [$clog2(TOTAL_WIDTH+1):0]    ball_pos_x,
  output logic [$clog2(TOTAL_HEIGHT+1):0]   ball_pos_y,
  output logic [3:0]                        score_1,
  output logic [3:0]                        score_2,
  output logic                              point_1,
  output logic                              point_2,
  output logic                              ball_in_play,
  output logic                              game_over
);

  import game_constants_pkg::*;

  localparam int XW = $clog2(TOTAL_WIDTH+1) + 1;
  localparam int YW = $clog2(TOTAL_HEIGHT+1) + 1;
  localparam int SW = (SERVE_DELAY_IN_STEPS > 1) ? $clog2(SERVE_DELAY_IN_STEPS) : 1;

  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [XW-1:0] SERVE_X = XW'(INITIAL_BALL_X);
  localparam logic [YW-1:0] SERVE_Y = YW'(INITIAL_BALL_Y);
  localparam logic [XW-1:0] BR      = XW'(TOTAL_WIDTH - BALL_SIDE_SIZE);
  localparam logic [YW-1:0] BB      = YW'(TOTAL_HEIGHT - BALL_SIDE_SIZE);
  localparam logic [XW-1:0] P1_FACE = XW'(INITIAL_PADDLE_1_X + PADDLE_WIDTH);
  localparam logic [XW:0]   P2_FACE = (XW+1)'(INITIAL_PADDLE_2_X);
  localparam logic [XW:0]   BALL_W  = (XW+1)'(BALL_SIDE_SIZE);
  localparam logic [YW:0]   BALL_H  = (YW+1)'(BALL_SIDE_SIZE);
  localparam logic [YW:0]   PAD_H   = (YW+1)'(PADDLE_HEIGHT);
  localparam logic [YW:0]   HALF_B  = (YW+1)'(BALL_SIDE_SIZE / 2);
  localparam logic [YW:0]   HALF_P  = (YW+1)'(PADDLE_HEIGHT / 2);
  localparam logic [YW:0]   OFS     = (YW+1)'(BALL_OFFSET_RANGE);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY_IN_STEPS - 1);
  localparam logic [SW-1:0] SERVE_ONE  = SW'(1);
  localparam logic [3:0]    WIN_SCORE  = 4'(WINNING_SCORE);

  // One extra MSB on every sum keeps the arithmetic unsigned and overflow-free
  function automatic logic overlaps(input logic [YW-1:0] y, input logic [YW-1:0] p);
    overlaps = (({1'b0, y} + BALL_H) > {1'b0, p}) && ({1'b0, y} < ({1'b0, p} + PAD_H));
  endfunction

  // Off-centre hits steer the ball away from the paddle centre
  function automatic dir_t deflect(input logic [YW-1:0] y, input logic [YW-1:0] p, input dir_t keep);
    logic [YW:0] ball_c;
    logic [YW:0] pad_c;
    ball_c = {1'b0, y} + HALF_B;
    pad_c  = {1'b0, p} + HALF_P;
    if ((ball_c + OFS) < pad_c) deflect = DIR_BACK;
    else if (ball_c > (pad_c + OFS)) deflect = DIR_FWD;
    else deflect = keep;
  endfunction

  logic        step;
  ball_state_t state;
  dir_t        dir_x;
  dir_t        dir_y;
  logic [SW-1:0] serve_cnt;

  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  dir_t          next_dir_x;
  dir_t          next_dir_y;
  dir_t          wall_dir_y;
  logic          hit_1;
  logic          hit_2;
  logic          miss_to_1;
  logic          miss_to_2;

  position_step_ticker #(
    .POSITION_CHANGE_FREQ_IN_CLOCKS(POSITION_CHANGE_FREQ_IN_CLOCKS)
  ) u_ticker (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  // Candidate ball motion for the next in-play step
  always_comb begin
    wall_dir_y = dir_y;
    if (dir_y == DIR_BACK && ball_pos_y == '0) begin
      wall_dir_y = DIR_FWD;
      next_y     = ball_pos_y + Y_ONE;
    end else if (dir_y == DIR_FWD && ball_pos_y == BB) begin
      wall_dir_y = DIR_BACK;
      next_y     = ball_pos_y - Y_ONE;
    end else if (dir_y == DIR_FWD) begin
      next_y = ball_pos_y + Y_ONE;
    end else begin
      next_y = ball_pos_y - Y_ONE;
    end

    hit_1 = (dir_x == DIR_BACK) && (ball_pos_x == P1_FACE) && overlaps(ball_pos_y, paddle_1_pos);
    hit_2 = (dir_x == DIR_FWD) && (({1'b0, ball_pos_x} + BALL_W) == P2_FACE)
            && overlaps(ball_pos_y, paddle_2_pos);
    miss_to_2 = (dir_x == DIR_BACK) && (ball_pos_x == '0);
    miss_to_1 = (dir_x == DIR_FWD) && (ball_pos_x == BR);

    next_dir_x = dir_x;
    next_dir_y = wall_dir_y;
    next_x     = (dir_x == DIR_FWD) ? ball_pos_x + X_ONE : ball_pos_x - X_ONE;
    if (hit_1) begin
      next_dir_x = DIR_FWD;
      next_x     = ball_pos_x + X_ONE;
      next_dir_y = deflect(ball_pos_y, paddle_1_pos, wall_dir_y);
    end else if (hit_2) begin
      next_dir_x = DIR_BACK;
      next_x     = ball_pos_x - X_ONE;
      next_dir_y = deflect(ball_pos_y, paddle_2_pos, wall_dir_y);
    end
  end

  // Serve / play / game-over sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SERVE_WAIT;
      serve_cnt    <= '0;
      dir_x        <= DIR_FWD;
      dir_y        <= DIR_FWD;
      ball_pos_x   <= SERVE_X;
      ball_pos_y   <= SERVE_Y;
      score_1      <= '0;
      score_2      <= '0;
      point_1      <= 1'b0;
      point_2      <= 1'b0;
      ball_in_play <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      point_1 <= 1'b0;
      point_2 <= 1'b0;
      if (step) begin
        case (state)
          SERVE_WAIT: begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt    <= '0;
              state        <= IN_PLAY;
              ball_in_play <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + SERVE_ONE;
            end
          end
          IN_PLAY: begin
            if (!(hit_1 || hit_2) && (miss_to_1 || miss_to_2)) begin
              ball_pos_x   <= SERVE_X;
              ball_pos_y   <= SERVE_Y;
              dir_y        <= DIR_FWD;
              ball_in_play <= 1'b0;
              if (miss_to_1) begin
                score_1 <= score_1 + 4'd1;
                point_1 <= 1'b1;
                dir_x   <= DIR_FWD;
                if ((score_1 + 4'd1) == WIN_SCORE) begin
                  state     <= GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  state <= SERVE_WAIT;
                end
              end else begin
                score_2 <= score_2 + 4'd1;
                point_2 <= 1'b1;
                dir_x   <= DIR_BACK;
                if ((score_2 + 4'd1) == WIN_SCORE) begin
                  state     <= GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  state <= SERVE_WAIT;
                end
              end
            end else begin
              ball_pos_x <= next_x;
              ball_pos_y <= next_y;
              dir_x      <= next_dir_x;
              dir_y      <= next_dir_y;
            end
          end
          GAME_OVER: begin
            state <= GAME_OVER;
          end
          default: begin
            state <= SERVE_WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: directed game scenarios plus randomized
// paddle traffic, all checked cycle by cycle against a behavioural model.
module tb_ball_motion_engine;

  localparam int TW = 64, TH = 48, PH = 12, PW = 2, P1X = 4, P2X = 58;
  localparam int BS = 2, SX = 31, SY = 23, OR = 2;
  localparam int FREQ = 4, SD = 3, WIN = 2;
  localparam int BR = TW - BS, BB = TH - BS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] paddle_1_pos = '0;
  logic [6:0] paddle_2_pos = '0;
  logic [7:0] ball_pos_x;
  logic [6:0] ball_pos_y;
  logic [3:0] score_1, score_2;
  logic       point_1, point_2, ball_in_play, game_over;

  always #5 clk = ~clk;

  ball_motion_engine #(
    .POSITION_CHANGE_FREQ_IN_CLOCKS(FREQ), .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH),
    .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH), .BALL_SIDE_SIZE(BS), .BALL_OFFSET_RANGE(OR),
    .INITIAL_PADDLE_1_X(P1X), .INITIAL_PADDLE_2_X(P2X), .INITIAL_BALL_X(SX),
    .INITIAL_BALL_Y(SY), .SERVE_DELAY_IN_STEPS(SD), .WINNING_SCORE(WIN)
  ) dut (
    .clk(clk), .rst(rst), .paddle_1_pos(paddle_1_pos), .paddle_2_pos(paddle_2_pos),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y), .score_1(score_1), .score_2(score_2),
    .point_1(point_1), .point_2(point_2), .ball_in_play(ball_in_play), .game_over(game_over)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model: signed velocities, plain integers
  int m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pt1, m_pt2, m_tick, m_serve;
  bit m_play, m_over;

  function automatic bit overlaps(input int y, input int p);
    return (y + BS > p) && (y < p + PH);
  endfunction

  task automatic model_reset();
    m_x = SX; m_y = SY; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_pt1 = 0; m_pt2 = 0;
    m_tick = 0; m_serve = 0; m_play = 0; m_over = 0;
  endtask

  task automatic model_score(input int who);
    if (who == 1) begin m_s1++; m_pt1 = 1; m_dx = 1; end
    else begin m_s2++; m_pt2 = 1; m_dx = -1; end
    m_x = SX; m_y = SY; m_dy = 1; m_play = 0; m_serve = 0;
    if ((who == 1 ? m_s1 : m_s2) == WIN) m_over = 1;
  endtask

  task automatic model_step(input int p1, input int p2);
    int ox, oy, ny, pc, bc;
    bit h1, h2;
    if (m_over) return;
    if (!m_play) begin
      m_serve++;
      if (m_serve == SD) begin m_play = 1; m_serve = 0; end
      return;
    end
    ox = m_x; oy = m_y;
    if ((oy == 0 && m_dy < 0) || (oy == BB && m_dy > 0)) m_dy = -m_dy;
    ny = oy + m_dy;
    h1 = (m_dx < 0) && (ox == P1X + PW) && overlaps(oy, p1);
    h2 = (m_dx > 0) && (ox + BS == P2X) && overlaps(oy, p2);
    if (h1 || h2) begin
      pc = (h1 ? p1 : p2) + PH / 2;
      bc = oy + BS / 2;
      m_dx = -m_dx;
      m_x  = ox + m_dx;
      if (bc < pc - OR) m_dy = -1;
      else if (bc > pc + OR) m_dy = 1;
      m_y = ny;
    end else if (m_dx < 0 && ox == 0) begin
      model_score(2);
    end else if (m_dx > 0 && ox == BR) begin
      model_score(1);
    end else begin
      m_x = ox + m_dx;
      m_y = ny;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin model_reset(); return; end
    m_pt1 = 0; m_pt2 = 0;
    if (m_tick == FREQ - 1) model_step(int'(paddle_1_pos), int'(paddle_2_pos));
    m_tick = (m_tick + 1) % FREQ;
  endtask

  task automatic compare_all();
    check_val("ball_x", ball_pos_x, m_x);
    check_val("ball_y", ball_pos_y, m_y);
    check_val("score_1", score_1, m_s1);
    check_val("score_2", score_2, m_s2);
    check_val("point_1", point_1, m_pt1);
    check_val("point_2", point_2, m_pt2);
    check_val("in_play", ball_in_play, int'(m_play));
    check_val("game_over", game_over, int'(m_over));
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [6:0] clamp_pos(input int v);
    if (v < 0) return 7'd0;
    if (v > 127) return 7'd127;
    return 7'(v);
  endfunction

  // 0/1 tight tracking, 2 loose tracking, 3 random, 4 kept away from the ball
  task automatic drive_paddles(input int mode);
    case (mode)
      0, 1: begin
        paddle_1_pos = clamp_pos(m_y + 1 - int'($urandom_range(0, 12)));
        paddle_2_pos = clamp_pos(m_y + 1 - int'($urandom_range(0, 12)));
      end
      2: begin
        paddle_1_pos = clamp_pos(m_y + 1 - int'($urandom_range(0, 16)));
        paddle_2_pos = clamp_pos(m_y + 1 - int'($urandom_range(0, 16)));
      end
      3: begin
        paddle_1_pos = 7'($urandom_range(0, 127));
        paddle_2_pos = 7'($urandom_range(0, 127));
      end
      default: begin
        paddle_1_pos = (m_y < 24) ? 7'd36 : 7'd0;
        paddle_2_pos = (m_y < 24) ? 7'd36 : 7'd0;
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pulses, moved;
    model_reset();

    // Reset held for a few cycles
    repeat (3) cyc();
    check_val("rst_x", ball_pos_x, SX);
    check_val("rst_y", ball_pos_y, SY);
    check_val("rst_in_play", ball_in_play, 0);

    // Release: steps on edges 3/7/11, play from edge 11, first move on edge 15
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_paddles(4);
      cyc();
      if (i == 10) check_val("serve_hold", ball_in_play, 0);
      if (i == 11) check_val("serve_release", ball_in_play, 1);
      if (i == 14) check_val("first_move_x_before", ball_pos_x, SX);
      if (i == 15) begin
        check_val("first_move_x", ball_pos_x, SX + 1);
        check_val("first_move_y", ball_pos_y, SY + 1);
      end
    end

    // Paddles kept away: player 1 scores
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin drive_paddles(4); cyc(); if (point_1) ok = 1; end
    check_val("point1_seen", ok, 1);
    check_val("point1_score", score_1, 1);
    check_val("point1_x", ball_pos_x, SX);
    check_val("point1_y", ball_pos_y, SY);
    check_val("point1_in_play", ball_in_play, 0);

    // Re-serve heads right
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin drive_paddles(4); cyc(); if (ball_in_play) ok = 1; end
    check_val("reserve_seen", ok, 1);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin drive_paddles(4); cyc(); if (ball_pos_x != SX) ok = 1; end
    check_val("reserve_moved", ok, 1);
    check_val("serve_right", ball_pos_x, SX + 1);

    // Second point ends the game
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin drive_paddles(4); cyc(); if (point_1) ok = 1; end
    check_val("point2_seen", ok, 1);
    check_val("final_score", score_1, WIN);
    check_val("over_flag", game_over, 1);

    // Frozen for 100 steps
    pulses = 0; moved = 0;
    for (int k = 0; k < 400; k++) begin
      drive_paddles(3);
      cyc();
      if (point_1 || point_2) pulses++;
      if (ball_pos_x != SX || ball_pos_y != SY || !game_over || ball_in_play) moved++;
    end
    check_val("over_pulses", pulses, 0);
    check_val("over_frozen", moved, 0);

    // One-cycle reset leaves game over
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_val("over_rst_score", score_1, 0);
    check_val("over_rst_flag", game_over, 0);
    check_val("over_rst_x", ball_pos_x, SX);

    // Reset in the middle of a rally
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      drive_paddles(0);
      cyc();
      if (m_play && m_x == 40) ok = 1;
    end
    check_val("rally_x40_seen", ok, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_val("mid_rst_x", ball_pos_x, SX);
    check_val("mid_rst_y", ball_pos_y, SY);
    check_val("mid_rst_in_play", ball_in_play, 0);

    // Randomized traffic with occasional resets
    for (int blk = 0; blk < 40; blk++) begin
      int mode;
      mode = int'($urandom_range(0, 4));
      if (m_over) begin rst = 1'b0; cyc(); rst = 1'b1; end
      repeat (150) begin
        drive_paddles(mode);
        rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        cyc();
      end
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
